word_serializer: RTL
====================

// Module: word_serializer
// PURPOSE
//   Upstream feeder for the serial sequence detector (moore_non_ol). Accepts
//   parallel words over a valid/ready handshake and shifts them out one bit per
//   clock on bit_out, which connects to the detector's 'in'.
//   A one-deep holding register lets consecutive words stream with no idle cycle.
//   bit_out is forced to 0 whenever no word is being shifted; the detector sees those 0s as real input.
// PARAMETERS
//   WIDTH      8   bits per word (>=2)
//   MSB_FIRST  1   1: word_in[WIDTH-1] is shifted first; 0: word_in[0] is shifted first
// PORTS
//   clk         in   1      single clock, rising edge
//   rst         in   1      asynchronous, active-low reset
//   word_in     in   WIDTH  parallel word; sampled when word_valid && word_ready
//   word_valid  in   1      upstream offers word_in
//   word_ready  out  1      block can accept a word this cycle; = !hold_full (combinational from registers)
//   bit_out     out  1      serial bit to detector; 0 when bit_valid=0
//   bit_valid   out  1      bit_out carries a word bit this cycle
//   last_bit    out  1      high on the final bit of each word
//   busy        out  1      shifting or holding a word
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, shreg=0, cnt=0, hold_full=0.
//     Outputs during and after reset: bit_out=0, bit_valid=0, last_bit=0, busy=0, word_ready=1.
//   State machine (2 states):
//     IDLE:  accept -> shreg<=word_in, cnt<=WIDTH-1, ->SHIFT. Stays IDLE otherwise.
//     SHIFT: each clock, shift shreg one bit toward the output end and decrement cnt.
//            If cnt==0:
//              - hold_full: shreg<=hold, cnt<=WIDTH-1, hold_full<=0, stay in SHIFT.
//              - else if an accept occurs this cycle: load word_in directly, stay in SHIFT.
//              - else ->IDLE.
//            If cnt!=0 and an accept occurs: hold<=word_in, hold_full<=1.
//   Outputs (decoded from registers, no combinational input-to-output path):
//     bit_valid = (state==SHIFT)
//     bit_out   = bit_valid & (MSB_FIRST ? shreg[WIDTH-1] : shreg[0])
//     last_bit  = bit_valid & (cnt==0)
//     busy      = bit_valid | hold_full
//   Latency: word accepted at edge N -> first bit on bit_out after edge N.
//     The word's bits occupy WIDTH consecutive cycles.
//   Throughput: one bit per clock, with no gap between words while upstream keeps word_valid high.
//   Boundaries:
//     - word_ready=0 only while hold_full=1. A full hold and an accept can never coincide.
//     - Hold drains at cnt==0. word_ready rises on the following cycle, not in the same cycle.
//     - word_valid while word_ready=0 is ignored. No data loss; upstream must hold the word.
//     - Reset mid-word discards the shift register and the hold register. No partial word resumes.
//   cnt width: $clog2(WIDTH). Counts down and never wraps below 0 while in SHIFT.
// STRUCTURE
//   Shared header seqdet_defs.vh holds the state encodings (ST_IDLE=1'b0, ST_SHIFT=1'b1).
//   It is shared with the detector for bench use.
//   Single module with no sub-module. Contents:
//     - shift register and down-counter
//     - hold register with hold_full flag
//     - one state register
// TESTING (bench drives clk with a 10 ns period; DUT output feeds moore_non_ol)
//   1. Reset: rst=0 mid-run -> all outputs 0 and word_ready=1 immediately.
//      They remain so until the first accept after rst=1.
//   2. Single word 8'b1011_0000, MSB_FIRST=1:
//      -> bit_out = 1,0,1,1,0,0,0,0 on 8 consecutive cycles. bit_valid high exactly 8 cycles.
//      -> last_bit high on the 8th cycle. The detector asserts detected once.
//   3. Back-to-back words 8'hB0 then 8'hB0, word_valid held high:
//      -> 16 contiguous bit_valid cycles with no gap.
//      -> word_ready=0 from the second accept until the first word's last_bit+1.
//   4. New word offered exactly in the last_bit cycle with the hold empty -> loaded directly, no idle cycle.
//   5. MSB_FIRST=0, word 8'h0D -> bit_out = 1,0,1,1,0,0,0,0.
//   6. rst=0 during the 4th bit of a word with the hold full -> bit_valid=0 immediately.
//      After release, nothing further is output until a new accept.

Source files
------------

// File: rtl/word_serializer_pkg.sv
// Shared types and constants for the word serializer feeding the serial sequence detector.
// State encodings match the ones the detector bench uses (ST_IDLE=0, ST_SHIFT=1).
package word_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_t;

    localparam int DEF_WIDTH     = 8;
    localparam bit DEF_MSB_FIRST = 1'b1;

endpackage

// File: rtl/word_serializer.sv
// Parallel-to-serial feeder: valid/ready word input, one bit per clock on bit_out,
// with a one-deep holding register so consecutive words stream without an idle cycle.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | nothing shifting; bit_out forced to 0; hold always empty
// ST_SHIFT | shreg drives bit_out; cnt = bits remaining after this one
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit MSB_FIRST = DEF_MSB_FIRST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             last_bit,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    ser_state_t       state, state_nx;
    logic [WIDTH-1:0] shreg, shreg_nx, shreg_shifted;
    logic [WIDTH-1:0] hold, hold_nx;
    logic             hold_full, hold_full_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             accept;

    assign word_ready = !hold_full;
    assign accept     = word_valid && word_ready;

    // Shift toward whichever end drives bit_out; vacated bits fill with 0.
    generate
        if (MSB_FIRST) begin : g_msb
            assign shreg_shifted = {shreg[WIDTH-2:0], 1'b0};
        end else begin : g_lsb
            assign shreg_shifted = {1'b0, shreg[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_nx     = state;
        shreg_nx     = shreg;
        cnt_nx       = cnt;
        hold_nx      = hold;
        hold_full_nx = hold_full;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    shreg_nx = word_in;
                    cnt_nx   = CNT_LAST;
                    state_nx = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shreg_nx = shreg_shifted;
                if (cnt == '0) begin
                    // A full hold blocks accept, so the two branches never compete.
                    if (hold_full) begin
                        shreg_nx     = hold;
                        cnt_nx       = CNT_LAST;
                        hold_full_nx = 1'b0;
                    end else if (accept) begin
                        shreg_nx = word_in;
                        cnt_nx   = CNT_LAST;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                    if (accept) begin
                        hold_nx      = word_in;
                        hold_full_nx = 1'b1;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            cnt       <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            state     <= state_nx;
            shreg     <= shreg_nx;
            cnt       <= cnt_nx;
            hold      <= hold_nx;
            hold_full <= hold_full_nx;
        end
    end

    assign bit_valid = (state == ST_SHIFT);
    assign bit_out   = bit_valid & (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
    assign last_bit  = bit_valid & (cnt == '0);
    assign busy      = bit_valid | hold_full;

endmodule
